mold_msg_tracker: RTL

//  Parses the MoldUDP64 payload beat stream, downstream of the keep-to-byte-count stage. Extracts header

---
 rtl/mold_pkg.sv | 18 +
 rtl/mold_msg_tracker_if.sv | 36 +++
 rtl/mold_len_capture.sv | 60 ++++++
 rtl/mold_msg_tracker.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mold_pkg.sv
// rtl/mold_pkg.sv - shared MoldUDP64 constants and tracker state type
package mold_pkg;

    localparam int MOLD_HDR_BYTES = 20;
    localparam int MOLD_SID_W     = 80;
    localparam int MOLD_SEQ_W     = 64;
    localparam int MOLD_LEN_W     = 16;
    localparam logic [15:0] MOLD_EOS_CNT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LEN,
        ST_DATA,
        ST_DROP
    } mold_state_e;

endpackage

// File: rtl/mold_msg_tracker_if.sv
// rtl/mold_msg_tracker_if.sv - payload beat stream in, parse results out
interface mold_msg_tracker_if #(
    parameter int D_W   = 8,
    parameter int D_LW  = 4,
    parameter int LEN_W = 16
);
    import mold_pkg::*;

    logic                   valid_i;
    logic                   start_i;
    logic                   last_i;
    logic [8*D_W-1:0]       data_i;
    logic [D_LW-1:0]        len_i;
    logic                   hdr_v_o;
    logic [MOLD_SID_W-1:0]  sid_o;
    logic [MOLD_SEQ_W-1:0]  seq_o;
    logic [LEN_W-1:0]       msg_cnt_o;
    logic                   eos_o;
    logic                   msg_len_v_o;
    logic [LEN_W-1:0]       msg_len_o;
    logic                   msg_end_v_o;
    logic [$clog2(D_W)-1:0] msg_end_off_o;
    logic                   err_o;

    modport slave (
        input  valid_i, start_i, last_i, data_i, len_i,
        output hdr_v_o, sid_o, seq_o, msg_cnt_o, eos_o, msg_len_v_o, msg_len_o,
               msg_end_v_o, msg_end_off_o, err_o
    );

    modport master (
        output valid_i, start_i, last_i, data_i, len_i,
        input  hdr_v_o, sid_o, seq_o, msg_cnt_o, eos_o, msg_len_v_o, msg_len_o,
               msg_end_v_o, msg_end_off_o, err_o
    );
endinterface

// File: rtl/mold_len_capture.sv
// rtl/mold_len_capture.sv - assembles a 2-byte big-endian length field starting at a byte offset,
// continuing from an upper byte held over from the previous beat
module mold_len_capture #(
    parameter int D_W   = 8,
    parameter int D_LW  = 4,
    parameter int LEN_W = 16
) (
    input  logic             i_en,
    input  logic [8*D_W-1:0] i_data,
    input  logic [D_LW-1:0]  i_len,
    input  logic [D_LW:0]    i_off,
    input  logic             i_hi_v,
    input  logic [7:0]       i_hi,
    output logic             o_valid,
    output logic [LEN_W-1:0] o_len,
    output logic [1:0]       o_cons,
    output logic             o_hi_v,
    output logic [7:0]       o_hi
);
    localparam int AW = $clog2(D_W);

    logic [D_LW:0]   w_avail;
    logic [AW-1:0]   w_i0;
    logic [AW-1:0]   w_i1;
    logic [7:0]      w_b0;
    logic [7:0]      w_b1;

    assign w_avail = ({1'b0, i_len} > i_off) ? ({1'b0, i_len} - i_off) : '0;
    assign w_i0    = i_off[AW-1:0];
    assign w_i1    = w_i0 + 1'b1;
    assign w_b0    = i_data[{w_i0, 3'b000} +: 8];
    assign w_b1    = i_data[{w_i1, 3'b000} +: 8];

    always_comb begin
        o_valid = 1'b0;
        o_len   = '0;
        o_cons  = 2'd0;
        o_hi_v  = 1'b0;
        o_hi    = i_hi;
        if (i_en) begin
            if (i_hi_v) begin
                if (w_avail != '0) begin
                    o_valid = 1'b1;
                    o_len   = LEN_W'({i_hi, w_b0});
                    o_cons  = 2'd1;
                end else begin
                    o_hi_v = 1'b1;
                end
            end else if (w_avail >= (D_LW+1)'(2)) begin
                o_valid = 1'b1;
                o_len   = LEN_W'({w_b0, w_b1});
                o_cons  = 2'd2;
            end else if (w_avail == (D_LW+1)'(1)) begin
                o_hi_v = 1'b1;
                o_hi   = w_b0;
                o_cons = 2'd1;
            end
        end
    end
endmodule

// File: rtl/mold_msg_tracker.sv
// rtl/mold_msg_tracker.sv - MoldUDP64 header extraction and per-beat message length/end tracking
module mold_msg_tracker
    import mold_pkg::*;
#(
    parameter int D_W   = 8,
    parameter int D_LW  = 4,
    parameter int LEN_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    mold_msg_tracker_if.slave bus
);
    localparam int AW = $clog2(D_W);
    localparam int PW = D_LW + 1;
    localparam int HB = MOLD_HDR_BYTES - 2*D_W;
    localparam logic [PW-1:0] HB_P = PW'(HB);

    mold_state_e          r_state;
    logic [1:0]           r_hcnt;
    logic [16*D_W-1:0]    r_hdr;
    logic [LEN_W-1:0]     r_rem, r_left;
    logic                 r_hi_v, r_strict;
    logic [7:0]           r_hi;
    logic                 r_hdr_v, r_eos, r_len_v, r_end_v, r_err;
    logic [MOLD_SID_W-1:0] r_sid;
    logic [MOLD_SEQ_W-1:0] r_seq;
    logic [LEN_W-1:0]     r_cnt, r_msg_len;
    logic [AW-1:0]        r_end_off;

    logic [8*D_W-1:0]     w_be;
    logic [MOLD_HDR_BYTES*8-1:0] w_hdr_full;
    logic [PW-1:0]        w_len;

    always_comb begin
        w_be = '0;
        for (int b = 0; b < D_W; b++) w_be[(D_W-1-b)*8 +: 8] = bus.data_i[b*8 +: 8];
    end
    assign w_hdr_full = {r_hdr, w_be[8*D_W-1 -: 8*HB]};
    assign w_len      = PW'(bus.len_i);

    // Phase A: header bytes, or the tail of a message already in flight
    mold_state_e      w_st, w_a_state;
    logic [1:0]       w_hc0, w_a_hcnt;
    logic [PW-1:0]    w_a_p;
    logic [LEN_W-1:0] w_a_rem, w_a_left;
    logic             w_a_err, w_a_end_v, w_a_hdr_v, w_a_eos, w_a_need, w_a_hi_v, w_a_strict;
    logic [AW-1:0]    w_a_end_off;

    always_comb begin
        w_st = r_state;
        w_a_err = 1'b0;
        if (bus.start_i) begin
            w_a_err = (r_state != ST_IDLE);
            w_st    = ST_HDR;
        end
        w_hc0       = bus.start_i ? 2'd0 : r_hcnt;
        w_a_hcnt    = w_hc0;
        w_a_state   = w_st;
        w_a_p       = '0;
        w_a_rem     = r_rem;
        w_a_left    = r_left;
        w_a_end_v   = 1'b0;
        w_a_end_off = '0;
        w_a_hdr_v   = 1'b0;
        w_a_eos     = 1'b0;
        w_a_need    = 1'b0;
        w_a_hi_v    = 1'b0;
        w_a_strict  = r_strict;
        case (w_st)
            ST_HDR: begin
                if (w_hc0 != 2'd2) begin
                    w_a_hcnt = w_hc0 + 2'd1;
                    w_a_p    = w_len;
                end else if (w_len >= HB_P) begin
                    w_a_hdr_v  = 1'b1;
                    w_a_p      = HB_P;
                    w_a_left   = LEN_W'(w_hdr_full[15:0]);
                    w_a_strict = 1'b0;
                    if (w_hdr_full[15:0] == 16'd0) begin
                        w_a_state = ST_DROP;
                    end else if (w_hdr_full[15:0] == MOLD_EOS_CNT) begin
                        w_a_eos   = 1'b1;
                        w_a_state = ST_DROP;
                    end else begin
                        w_a_need = 1'b1;
                    end
                end
            end
            ST_LEN: begin
                w_a_need = 1'b1;
                w_a_hi_v = r_hi_v;
            end
            ST_DATA: begin
                if (r_rem <= LEN_W'(w_len)) begin
                    w_a_end_v   = 1'b1;
                    w_a_end_off = AW'(r_rem - LEN_W'(1));
                    w_a_p       = PW'(r_rem);
                    w_a_rem     = '0;
                    w_a_left    = r_left - LEN_W'(1);
                    if (w_a_left == '0) begin
                        w_a_state  = ST_DROP;
                        w_a_strict = 1'b1;
                        w_a_err    = w_a_err | (w_a_p < w_len);
                    end else begin
                        w_a_need = 1'b1;
                    end
                end else begin
                    w_a_rem = r_rem - LEN_W'(w_len);
                end
            end
            ST_DROP: w_a_err = w_a_err | r_strict;
            default: ;
        endcase
    end

    logic             w_cap_v, w_cap_hi_v;
    logic [LEN_W-1:0] w_cap_len;
    logic [1:0]       w_cap_cons;
    logic [7:0]       w_cap_hi;

    mold_len_capture #(.D_W(D_W), .D_LW(D_LW), .LEN_W(LEN_W)) u_len_cap (
        .i_en    (w_a_need),
        .i_data  (bus.data_i),
        .i_len   (bus.len_i),
        .i_off   (w_a_p),
        .i_hi_v  (w_a_hi_v),
        .i_hi    (r_hi),
        .o_valid (w_cap_v),
        .o_len   (w_cap_len),
        .o_cons  (w_cap_cons),
        .o_hi_v  (w_cap_hi_v),
        .o_hi    (w_cap_hi)
    );

    // Phase B: a new length field and, if short enough, the whole message behind it
    mold_state_e      w_n_state;
    logic [PW-1:0]    w_n_p, w_tail;
    logic [LEN_W-1:0] w_n_rem, w_n_left, w_avail;
    logic             w_n_err, w_n_end_v, w_n_len_v, w_n_hi_v, w_n_strict;
    logic [7:0]       w_n_hi;
    logic [AW-1:0]    w_n_end_off;

    always_comb begin
        w_n_state   = w_a_state;
        w_n_p       = w_a_p;
        w_tail      = '0;
        w_avail     = '0;
        w_n_rem     = w_a_rem;
        w_n_left    = w_a_left;
        w_n_err     = w_a_err;
        w_n_end_v   = w_a_end_v;
        w_n_end_off = w_a_end_off;
        w_n_len_v   = 1'b0;
        w_n_hi_v    = 1'b0;
        w_n_hi      = r_hi;
        w_n_strict  = w_a_strict;
        if (w_a_need) begin
            w_n_state = ST_LEN;
            w_n_hi_v  = w_cap_hi_v;
            w_n_hi    = w_cap_hi;
            if (w_cap_v) begin
                w_n_len_v = 1'b1;
                w_n_p     = w_a_p + PW'(w_cap_cons);
                w_n_rem   = w_cap_len;
                w_avail   = LEN_W'(w_len - w_n_p);
                if (w_cap_len <= w_avail) begin
                    if (w_a_end_v) begin
                        w_n_err    = 1'b1;
                        w_n_state  = ST_DROP;
                        w_n_strict = 1'b0;
                    end else begin
                        w_n_end_v   = 1'b1;
                        w_n_end_off = AW'(LEN_W'(w_n_p) + w_cap_len - LEN_W'(1));
                        w_n_p       = w_n_p + PW'(w_cap_len);
                        w_n_rem     = '0;
                        w_n_left    = w_a_left - LEN_W'(1);
                        w_tail      = w_len - w_n_p;
                        if (w_n_left == '0) begin
                            w_n_state  = ST_DROP;
                            w_n_strict = 1'b1;
                            w_n_err    = w_n_err | (w_tail != '0);
                        end else if (w_tail >= PW'(2)) begin
                            w_n_err    = 1'b1;
                            w_n_state  = ST_DROP;
                            w_n_strict = 1'b0;
                        end else if (w_tail == PW'(1)) begin
                            w_n_hi_v = 1'b1;
                            w_n_hi   = bus.data_i[{w_n_p[AW-1:0], 3'b000} +: 8];
                        end
                    end
                end else begin
                    w_n_rem   = w_cap_len - w_avail;
                    w_n_state = ST_DATA;
                end
            end
        end
        if (bus.last_i) begin
            if (w_n_state inside {ST_HDR, ST_LEN, ST_DATA}) w_n_err = 1'b1;
            w_n_state  = ST_IDLE;
            w_n_strict = 1'b0;
            w_n_hi_v   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_hcnt <= '0; r_hdr <= '0; r_rem <= '0; r_left <= '0;
            r_hi_v <= 1'b0; r_hi <= '0; r_strict <= 1'b0;
            r_hdr_v <= 1'b0; r_eos <= 1'b0; r_len_v <= 1'b0; r_end_v <= 1'b0; r_err <= 1'b0;
            r_sid <= '0; r_seq <= '0; r_cnt <= '0; r_msg_len <= '0; r_end_off <= '0;
        end else begin
            r_hdr_v <= 1'b0;
            r_len_v <= 1'b0;
            r_end_v <= 1'b0;
            r_err   <= 1'b0;
            if (bus.valid_i) begin
                r_state  <= w_n_state;
                r_hcnt   <= w_a_hcnt;
                r_rem    <= w_n_rem;
                r_left   <= w_n_left;
                r_hi_v   <= w_n_hi_v;
                r_hi     <= w_n_hi;
                r_strict <= w_n_strict;
                r_hdr_v  <= w_a_hdr_v;
                r_len_v  <= w_n_len_v;
                r_end_v  <= w_n_end_v;
                r_err    <= w_n_err;
                if (w_st == ST_HDR) r_hdr <= {r_hdr[8*D_W-1:0], w_be};
                if (w_a_hdr_v) begin
                    r_sid <= w_hdr_full[159:80];
                    r_seq <= w_hdr_full[79:16];
                    r_cnt <= LEN_W'(w_hdr_full[15:0]);
                    r_eos <= w_a_eos;
                end
                if (w_n_len_v) r_msg_len <= w_cap_len;
                if (w_n_end_v) r_end_off <= w_n_end_off;
            end
        end
    end

    assign bus.hdr_v_o       = r_hdr_v;
    assign bus.sid_o         = r_sid;
    assign bus.seq_o         = r_seq;
    assign bus.msg_cnt_o     = r_cnt;
    assign bus.eos_o         = r_eos;
    assign bus.msg_len_v_o   = r_len_v;
    assign bus.msg_len_o     = r_msg_len;
    assign bus.msg_end_v_o   = r_end_v;
    assign bus.msg_end_off_o = r_end_off;
    assign bus.err_o         = r_err;
endmodule
